// File: rtl/z16_wb_pkg.sv
// z16_wb_pkg: shared widths and enums for the Z16 writeback unit
package z16_wb_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W = 16;
  typedef enum logic {SKID_EMPTY, SKID_HELD} skid_state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_LOAD, SRC_SKID, SRC_ALU} wb_src_t;
endpackage

// File: rtl/z16_wb_tag_fifo.sv
// z16_wb_tag_fifo: in-order FIFO of outstanding load destination registers
module z16_wb_tag_fifo
  import z16_wb_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [REG_ADDR_W-1:0]         din,
  output logic [REG_ADDR_W-1:0]         dout,
  output logic [$clog2(LD_DEPTH):0]     count,
  output logic                          full,
  output logic                          empty
);
  localparam int PW = $clog2(LD_DEPTH);
  logic [REG_ADDR_W-1:0] mem [LD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (PW+1)'(LD_DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/z16_writeback_unit.sv
// z16_writeback_unit: merges ALU results and in-order load returns onto the RD port; Z16_WB_BYPASS_EN adds rs forwarding ports
module z16_writeback_unit
  import z16_wb_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd_addr,
  input  logic [DATA_W-1:0]     i_alu_data,
  output logic                  o_alu_ready,
  input  logic                  i_ld_req_valid,
  input  logic [REG_ADDR_W-1:0] i_ld_rd_addr,
  output logic                  o_ld_req_ready,
  input  logic                  i_mem_rdata_valid,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic                  o_rd_wen,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_busy,
  output logic                  o_err
`ifdef Z16_WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  output logic                  o_rs1_fwd_valid,
  output logic [DATA_W-1:0]     o_rs1_fwd_data,
  output logic                  o_rs2_fwd_valid,
  output logic [DATA_W-1:0]     o_rs2_fwd_data
`endif
);
  localparam int CW = $clog2(LD_DEPTH) + 1;
  skid_state_t skid_state;
  wb_src_t src;
  logic [REG_ADDR_W-1:0] skid_addr, head, wb_addr;
  logic [DATA_W-1:0] skid_data, wb_data;
  logic [CW-1:0] count;
  logic full, empty, alu_acc, ld_push, ld_ret, wb_wen, collide;
  z16_wb_tag_fifo #(.LD_DEPTH(LD_DEPTH)) u_tag_fifo (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .push(ld_push),
    .pop(ld_ret),
    .din(i_ld_rd_addr),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  assign o_alu_ready = skid_state == SKID_EMPTY;
  assign o_ld_req_ready = count < CW'(LD_DEPTH);
  assign o_busy = !empty || skid_state == SKID_HELD;
  assign alu_acc = i_alu_valid && o_alu_ready;
  assign ld_push = i_ld_req_valid && !full;
  assign ld_ret = i_mem_rdata_valid && !empty;
  assign collide = ld_ret && alu_acc && i_alu_rd_addr != '0;
  always_comb begin
    src = ld_ret ? SRC_LOAD : skid_state == SKID_HELD ? SRC_SKID : alu_acc ? SRC_ALU : SRC_NONE;
    wb_addr = src == SRC_LOAD ? head : src == SRC_SKID ? skid_addr : i_alu_rd_addr;
    wb_data = src == SRC_LOAD ? i_mem_rdata : src == SRC_SKID ? skid_data : i_alu_data;
    wb_wen = src != SRC_NONE && wb_addr != '0;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      skid_state <= SKID_EMPTY;
      skid_addr <= '0;
      skid_data <= '0;
      o_rd_wen <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
      o_err <= 1'b0;
    end else begin
      o_rd_wen <= wb_wen;
      if (wb_wen) begin
        o_rd_addr <= wb_addr;
        o_rd_data <= wb_data;
      end
      if (i_mem_rdata_valid && empty) o_err <= 1'b1;
      if (collide) begin
        skid_state <= SKID_HELD;
        skid_addr <= i_alu_rd_addr;
        skid_data <= i_alu_data;
      end else if (src == SRC_SKID) begin
        skid_state <= SKID_EMPTY;
      end
    end
  end
`ifdef Z16_WB_BYPASS_EN
  assign o_rs1_fwd_valid = o_rd_wen && o_rd_addr == i_rs1_addr && i_rs1_addr != '0;
  assign o_rs2_fwd_valid = o_rd_wen && o_rd_addr == i_rs2_addr && i_rs2_addr != '0;
  assign o_rs1_fwd_data = o_rd_data;
  assign o_rs2_fwd_data = o_rd_data;
`endif
endmodule

// File: tb/tb_z16_writeback_unit.sv
// tb_z16_writeback_unit: directed self-checking bench for z16_writeback_unit
module tb_z16_writeback_unit;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_alu_valid = 1'b0;
  logic [3:0] i_alu_rd_addr = '0;
  logic [15:0] i_alu_data = '0;
  logic o_alu_ready;
  logic i_ld_req_valid = 1'b0;
  logic [3:0] i_ld_rd_addr = '0;
  logic o_ld_req_ready;
  logic i_mem_rdata_valid = 1'b0;
  logic [15:0] i_mem_rdata = '0;
  logic [3:0] o_rd_addr;
  logic o_rd_wen;
  logic [15:0] o_rd_data;
  logic o_busy;
  logic o_err;
  int checks = 0;
  int errors = 0;
`ifdef Z16_WB_BYPASS_EN
  logic [3:0] i_rs1_addr = '0;
  logic [3:0] i_rs2_addr = '0;
  logic o_rs1_fwd_valid, o_rs2_fwd_valid;
  logic [15:0] o_rs1_fwd_data, o_rs2_fwd_data;
`endif
  always #5 i_clk = ~i_clk;
  z16_writeback_unit #(.LD_DEPTH(4)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_alu_valid(i_alu_valid),
    .i_alu_rd_addr(i_alu_rd_addr),
    .i_alu_data(i_alu_data),
    .o_alu_ready(o_alu_ready),
    .i_ld_req_valid(i_ld_req_valid),
    .i_ld_rd_addr(i_ld_rd_addr),
    .o_ld_req_ready(o_ld_req_ready),
    .i_mem_rdata_valid(i_mem_rdata_valid),
    .i_mem_rdata(i_mem_rdata),
    .o_rd_addr(o_rd_addr),
    .o_rd_wen(o_rd_wen),
    .o_rd_data(o_rd_data),
    .o_busy(o_busy),
    .o_err(o_err)
`ifdef Z16_WB_BYPASS_EN
    ,
    .i_rs1_addr(i_rs1_addr),
    .i_rs2_addr(i_rs2_addr),
    .o_rs1_fwd_valid(o_rs1_fwd_valid),
    .o_rs1_fwd_data(o_rs1_fwd_data),
    .o_rs2_fwd_valid(o_rs2_fwd_valid),
    .o_rs2_fwd_data(o_rs2_fwd_data)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic chk_wr(input string tag, input logic [3:0] a, input logic [15:0] d);
    chk({tag, "_wen"}, 32'(o_rd_wen), 32'd1);
    chk({tag, "_addr"}, 32'(o_rd_addr), 32'(a));
    chk({tag, "_data"}, 32'(o_rd_data), 32'(d));
  endtask
  initial begin
    step();
    step();
    chk("rst_wen", 32'(o_rd_wen), 0);
    chk("rst_addr", 32'(o_rd_addr), 0);
    chk("rst_data", 32'(o_rd_data), 0);
    chk("rst_alu_ready", 32'(o_alu_ready), 1);
    chk("rst_ld_ready", 32'(o_ld_req_ready), 1);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_err", 32'(o_err), 0);
    i_rst = 1'b0;
    step();
    // plain ALU write
    i_alu_valid = 1'b1; i_alu_rd_addr = 4'd3; i_alu_data = 16'h1234;
    step();
    i_alu_valid = 1'b0;
    chk_wr("alu_r3", 4'd3, 16'h1234);
    step();
    chk("alu_pulse", 32'(o_rd_wen), 0);
    // collision: load return wins, ALU goes to skid
    i_ld_req_valid = 1'b1; i_ld_rd_addr = 4'd5;
    step();
    i_ld_req_valid = 1'b0;
    i_mem_rdata_valid = 1'b1; i_mem_rdata = 16'hBEEF;
    i_alu_valid = 1'b1; i_alu_rd_addr = 4'd6; i_alu_data = 16'h0001;
    step();
    i_mem_rdata_valid = 1'b0; i_alu_valid = 1'b0;
    chk_wr("col_ld_r5", 4'd5, 16'hBEEF);
    chk("col_alu_ready_c1", 32'(o_alu_ready), 0);
    chk("col_busy_c1", 32'(o_busy), 1);
    step();
    chk_wr("col_skid_r6", 4'd6, 16'h0001);
    chk("col_alu_ready_c2", 32'(o_alu_ready), 1);
    chk("col_busy_c2", 32'(o_busy), 0);
    // fill the tag FIFO
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("fill_ready_%0d", i), 32'(o_ld_req_ready), 1);
      i_ld_req_valid = 1'b1; i_ld_rd_addr = 4'(i);
      step();
    end
    chk("full_ready", 32'(o_ld_req_ready), 0);
    i_ld_rd_addr = 4'd9;
    step();
    i_ld_req_valid = 1'b0;
    chk("full_ready_held", 32'(o_ld_req_ready), 0);
    for (int i = 1; i <= 4; i++) begin
      i_mem_rdata_valid = 1'b1; i_mem_rdata = 16'(9 + i);
      step();
      chk_wr($sformatf("drain_%0d", i), 4'(i), 16'(9 + i));
      chk($sformatf("drain_busy_%0d", i), 32'(o_busy), (i == 4) ? 32'd0 : 32'd1);
    end
    i_mem_rdata_valid = 1'b0;
    step();
    chk("drain_idle_wen", 32'(o_rd_wen), 0);
    chk("drain_no_err", 32'(o_err), 0);
    // register 0 writes are discarded
    i_alu_valid = 1'b1; i_alu_rd_addr = 4'd0; i_alu_data = 16'h7E7E;
    i_ld_req_valid = 1'b1; i_ld_rd_addr = 4'd0;
    step();
    i_alu_valid = 1'b0; i_ld_req_valid = 1'b0;
    chk("r0_alu_wen", 32'(o_rd_wen), 0);
    chk("r0_busy", 32'(o_busy), 1);
    i_mem_rdata_valid = 1'b1; i_mem_rdata = 16'hFFFF;
    i_alu_valid = 1'b1; i_alu_rd_addr = 4'd0;
    step();
    i_mem_rdata_valid = 1'b0; i_alu_valid = 1'b0;
    chk("r0_ld_wen", 32'(o_rd_wen), 0);
    chk("r0_busy_after", 32'(o_busy), 0);
    chk("r0_alu_ready", 32'(o_alu_ready), 1);
    chk("r0_addr_kept", 32'(o_rd_addr), 32'd4);
    // return with empty FIFO, including a same-cycle push
    i_mem_rdata_valid = 1'b1; i_mem_rdata = 16'h7777;
    i_ld_req_valid = 1'b1; i_ld_rd_addr = 4'd2;
    step();
    i_ld_req_valid = 1'b0;
    chk("empty_ret_err", 32'(o_err), 1);
    chk("empty_ret_wen", 32'(o_rd_wen), 0);
    chk("empty_ret_busy", 32'(o_busy), 1);
    i_mem_rdata = 16'h8888;
    step();
    i_mem_rdata_valid = 1'b0;
    chk_wr("late_tag_r2", 4'd2, 16'h8888);
    chk("err_sticky", 32'(o_err), 1);
    // reset mid-operation with two tags outstanding
    i_ld_req_valid = 1'b1; i_ld_rd_addr = 4'd8;
    step();
    i_ld_rd_addr = 4'd9;
    step();
    i_ld_req_valid = 1'b0;
    chk("pre_rst_busy", 32'(o_busy), 1);
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(o_busy), 0);
    chk("async_rst_err", 32'(o_err), 0);
    chk("async_rst_ready", 32'(o_ld_req_ready), 1);
    step();
    i_rst = 1'b0;
    step();
    i_mem_rdata_valid = 1'b1; i_mem_rdata = 16'h4321;
    step();
    i_mem_rdata_valid = 1'b0;
    chk("stale_ret_err", 32'(o_err), 1);
    chk("stale_ret_wen", 32'(o_rd_wen), 0);
`ifdef Z16_WB_BYPASS_EN
    i_rs1_addr = 4'd0; i_rs2_addr = 4'd7;
    i_alu_valid = 1'b1; i_alu_rd_addr = 4'd7; i_alu_data = 16'h5555;
    step();
    i_alu_valid = 1'b0;
    #1;
    chk("fwd_rs2_valid", 32'(o_rs2_fwd_valid), 1);
    chk("fwd_rs2_data", 32'(o_rs2_fwd_data), 32'h5555);
    chk("fwd_rs1_valid", 32'(o_rs1_fwd_valid), 0);
`endif
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
